// File: rtl/iis_pkg.sv
// -----------------------------------------------------------------------------
// iis_pkg -- shared definitions for the I2S slave receiver.
//   iis_state_e    : receiver alignment state
//   IIS_DATA_W     : default received word width
//   IIS_FIFO_DEPTH : default output FIFO depth
// -----------------------------------------------------------------------------
package iis_pkg;

   localparam int IIS_DATA_W     = 16;
   localparam int IIS_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_WAIT_WS  = 2'd1,
      ST_SHIFT    = 2'd2
   } iis_state_e;

endpackage

// File: rtl/iis_rx_sync.sv
// -----------------------------------------------------------------------------
// iis_rx_sync -- brings the external I2S lines into the pclk domain.
//   clk_i, rst_i      : system clock, asynchronous active-high reset
//   sck_i, ws_i, sd_i : raw I2S bit clock, word select, serial data
//   sck_rise_o        : one-cycle pulse per detected sck rising edge
//   ws_o, sd_o        : ws/sd values sampled at that sck rise
// Each line goes through a two-flop synchroniser; a third registered stage
// produces the edge pulse together with ws/sd from the same sampling instant,
// so the three outputs are mutually aligned.
// -----------------------------------------------------------------------------
module iis_rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sck_i,
   input  logic ws_i,
   input  logic sd_i,
   output logic sck_rise_o,
   output logic ws_o,
   output logic sd_o
);

   logic [1:0] sck_sync_q;
   logic [1:0] ws_sync_q;
   logic [1:0] sd_sync_q;
   logic       sck_prev_q;
   logic       rise_q;
   logic       ws_q;
   logic       sd_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         rise_q     <= 1'b0;
         ws_q       <= 1'b0;
         sd_q       <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[0], sck_i};
         ws_sync_q  <= {ws_sync_q[0],  ws_i};
         sd_sync_q  <= {sd_sync_q[0],  sd_i};
         sck_prev_q <= sck_sync_q[1];
         // ws/sd are stable around the sck rise (they move on the falling
         // edge), so the synchronised copies match the rising-edge values.
         rise_q     <= sck_sync_q[1] & ~sck_prev_q;
         ws_q       <= ws_sync_q[1];
         sd_q       <= sd_sync_q[1];
      end
   end

   assign sck_rise_o = rise_q;
   assign ws_o       = ws_q;
   assign sd_o       = sd_q;

endmodule

// File: rtl/iis_slave_rx.sv
// -----------------------------------------------------------------------------
// iis_slave_rx -- I2S slave receiver with show-ahead output FIFO.
//   pclk, preset         : system clock, asynchronous active-high reset
//   sck_i, ws_i, sd_i    : external I2S lines (asynchronous to pclk)
//   en_i                 : receive enable; low discards any partial word
//   clr_i                : clears the sticky ovf_o / frame_err_o flags
//   lj_i                 : left-justified select (only with IIS_SLAVE_RX_LJ_EN)
//   m_valid_o/m_ready_i  : sample stream handshake, m_data_o word, m_ch_o
//                          channel (0 = left / ws low, 1 = right)
//   ovf_o                : sticky, a word was dropped because the FIFO was full
//   frame_err_o          : sticky, a slot ended with fewer than DATA_W bits
//   busy_o               : receiver is enabled (not in DISABLED)
//   level_o              : FIFO fill count
// Build option: define IIS_SLAVE_RX_LJ_EN to add lj_i and left-justified
// reception; without it the receiver is I2S only.
// -----------------------------------------------------------------------------
module iis_slave_rx
   import iis_pkg::*;
#(
   parameter int DATA_W     = IIS_DATA_W,
   parameter int FIFO_DEPTH = IIS_FIFO_DEPTH
) (
   input  logic                          pclk,
   input  logic                          preset,
   input  logic                          sck_i,
   input  logic                          ws_i,
   input  logic                          sd_i,
   input  logic                          en_i,
   input  logic                          clr_i,
`ifdef IIS_SLAVE_RX_LJ_EN
   input  logic                          lj_i,
`endif
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic [DATA_W-1:0]             m_data_o,
   output logic                          m_ch_o,
   output logic                          ovf_o,
   output logic                          frame_err_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   // synchronised bit stream
   logic sck_rise;
   logic ws_s;
   logic sd_s;

   iis_rx_sync u_sync (
      .clk_i      (pclk),
      .rst_i      (preset),
      .sck_i      (sck_i),
      .ws_i       (ws_i),
      .sd_i       (sd_i),
      .sck_rise_o (sck_rise),
      .ws_o       (ws_s),
      .sd_o       (sd_s)
   );

   logic lj_mode;
`ifdef IIS_SLAVE_RX_LJ_EN
   assign lj_mode = lj_i;
`else
   assign lj_mode = 1'b0;
`endif

   // receiver state and slot assembly
   iis_state_e        state_q, state_d;
   logic              ws_prev_q;
   logic              ws_seen_q;
   logic              ch_q, ch_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] shifted;
   logic              ws_change;
   logic              push;
   logic              push_ch;
   logic [DATA_W-1:0] push_word;
   logic              ferr_set;

   // A change needs a previous sample; ws_seen_q stops the first edge after
   // reset from looking like a transition against the reset value.
   assign ws_change = sck_rise && ws_seen_q && (ws_s != ws_prev_q);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= ST_DISABLED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = ST_DISABLED;
      end else begin
         case (state_q)
            ST_DISABLED: state_d = ST_WAIT_WS;
            ST_WAIT_WS:  if (ws_change) state_d = ST_SHIFT;
            default:     state_d = state_q;
         endcase
      end
   end

   always_comb begin
      busy_o    = (state_q != ST_DISABLED);
      ch_d      = ch_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      push_ch   = ch_q;
      push_word = shreg_q;
      ferr_set  = 1'b0;
      shifted   = {shreg_q[DATA_W-2:0], sd_s};
      if (!en_i || (state_q == ST_DISABLED)) begin
         cnt_d = '0;
      end else if (sck_rise) begin
         if (state_q == ST_WAIT_WS) begin
            // alignment edge: its bit belongs to an unknown slot, drop it
            if (ws_change) begin
               ch_d  = ws_s;
               cnt_d = '0;
            end
         end else if (ws_change && lj_mode) begin
            // left-justified: this bit is already the MSB of the new slot
            if (cnt_q == CNT_FULL) begin
               push = 1'b1;
            end else begin
               ferr_set = 1'b1;
            end
            ch_d    = ws_s;
            shreg_d = {{(DATA_W-1){1'b0}}, sd_s};
            cnt_d   = CNT_W'(1);
         end else if (ws_change) begin
            // I2S: ws leads data by one bit, so this is the old slot's last bit
            if (cnt_q == CNT_FULL) begin
               push = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               push      = 1'b1;
               push_word = shifted;
            end else begin
               ferr_set = 1'b1;
            end
            ch_d  = ws_s;
            cnt_d = '0;
         end else if (cnt_q != CNT_FULL) begin
            // bits beyond DATA_W in a long slot are ignored
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ws_prev_q <= 1'b0;
         ws_seen_q <= 1'b0;
         ch_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // ws is tracked even while disabled so re-enabling aligns on a
         // genuine transition rather than on a stale comparison
         if (sck_rise) begin
            ws_prev_q <= ws_s;
            ws_seen_q <= 1'b1;
         end
         ch_q  <= ch_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge pclk) begin
      shreg_q <= shreg_d;
   end

   // output FIFO: {channel, word} entries, show-ahead
   logic [DATA_W:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [DATA_W:0]    head;
   logic               empty;
   logic               full;
   logic               pop;
   logic               wr_en;
   logic               ovf_set;
   logic               ovf_q, ovf_d;
   logic               ferr_q, ferr_d;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_FULL);
   assign pop     = !empty && m_ready_i;
   // when full, a same-cycle pop frees the slot being written
   assign wr_en   = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge pclk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {push_ch, push_word};
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // sticky flags: a set in the same cycle as clr_i takes priority
   always_comb begin
      ovf_d  = ovf_set  ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
      ferr_d = ferr_set ? 1'b1 : (clr_i ? 1'b0 : ferr_q);
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         ferr_q <= ferr_d;
      end
   end

   // entry storage is not reset, so the head is masked while empty
   assign m_valid_o   = !empty;
   assign m_data_o    = empty ? '0   : head[DATA_W-1:0];
   assign m_ch_o      = empty ? 1'b0 : head[DATA_W];
   assign ovf_o       = ovf_q;
   assign frame_err_o = ferr_q;
   assign level_o     = level_q;

endmodule

// File: tb/tb_iis_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_iis_slave_rx -- self-checking bench for iis_slave_rx.
// Frames are described as a list of slots (channel, length, MSB-first bits).
// The expected output stream is derived from the slot list: every complete
// slot after the alignment slot yields {channel, top DATA_W bits}, a short
// slot raises frame_err, and words beyond the FIFO capacity raise ovf when
// nothing drains the FIFO.
// -----------------------------------------------------------------------------
module tb_iis_slave_rx;
   import iis_pkg::*;

   localparam int DW      = IIS_DATA_W;
   localparam int DEPTH   = IIS_FIFO_DEPTH;
   localparam int EV_NONE = 0;
   localparam int EV_EN   = 1;
   localparam int EV_RST  = 2;

   logic pclk = 1'b0;
   logic preset;
   logic sck_i, ws_i, sd_i, en_i, clr_i;
   logic m_ready_i = 1'b0;
   logic m_valid_o, m_ch_o, ovf_o, frame_err_o, busy_o;
   logic [DW-1:0] m_data_o;
   logic [$clog2(DEPTH):0] level_o;
`ifdef IIS_SLAVE_RX_LJ_EN
   logic lj_i;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;
   bit rdy_fix = 1'b1;
   bit rdy_rnd = 1'b0;

   // slot description and expectations
   bit          s_ch[$];
   int          s_len[$];
   logic [63:0] s_dat[$];
   logic [DW:0] exp_q[$];
   bit          exp_ferr;
   bit          exp_ovf;

   iis_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .pclk        (pclk),
      .preset      (preset),
      .sck_i       (sck_i),
      .ws_i        (ws_i),
      .sd_i        (sd_i),
      .en_i        (en_i),
      .clr_i       (clr_i),
`ifdef IIS_SLAVE_RX_LJ_EN
      .lj_i        (lj_i),
`endif
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_data_o    (m_data_o),
      .m_ch_o      (m_ch_o),
      .ovf_o       (ovf_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o),
      .level_o     (level_o)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ready driver, away from the sampling edge
   initial forever begin
      @(posedge pclk);
      #1;
      m_ready_i = rdy_rnd ? ($urandom_range(0, 1) == 1) : rdy_fix;
   end

   // scoreboard: each accepted beat must match the next expected word
   initial forever begin
      @(negedge pclk);
      if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
         if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
         else chk("word", 32'({m_ch_o, m_data_o}), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic add_slot(input bit ch, input int len, input logic [63:0] dat);
      s_ch.push_back(ch);
      s_len.push_back(len);
      s_dat.push_back(dat);
   endtask

   task automatic add_expect(input int lo, input int hi);
      for (int s = lo; s <= hi; s++) begin
         if (s_len[s] >= DW) exp_q.push_back({s_ch[s], s_dat[s][63 -: DW]});
         else exp_ferr = 1'b1;
      end
   endtask

   task automatic start_scn();
      @(negedge pclk);
      preset = 1'b1;
      en_i   = 1'b0;
      repeat (2) @(negedge pclk);
      preset = 1'b0;
      en_i   = 1'b1;
      repeat (2) @(negedge pclk);
      s_ch.delete();
      s_len.delete();
      s_dat.delete();
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   task automatic finish_scn(input string name);
      repeat (30) @(negedge pclk);
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_ferr"}, 32'(frame_err_o), 32'(exp_ferr));
      chk({name, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
   endtask

   // Serialise the slot list: sck period 8 pclk, ws/sd move with sck falling.
   // In I2S ws announces the next slot one bit early; in LJ it is coincident.
   task automatic run_stream(input bit lj, input int ev_kind, input int ev_idx, input int watch_idx);
      bit e_ch[$];
      bit e_bit[$];
      int n;
      for (int s = 0; s < s_len.size(); s++)
         for (int b = 0; b < s_len[s]; b++) begin
            e_ch.push_back(s_ch[s]);
            e_bit.push_back(s_dat[s][63 - b]);
         end
      n = e_ch.size();
      @(negedge pclk);
      for (int k = 0; k < n; k++) begin
         sck_i = 1'b0;
         sd_i  = e_bit[k];
         ws_i  = (lj || (k + 1 >= n)) ? e_ch[k] : e_ch[k + 1];
         if (ev_kind == EV_EN && k == ev_idx) begin
            en_i = 1'b0;
            #8 chk("en_off_busy", 32'(busy_o), 32'd0);
            #32;
         end else if (ev_kind == EV_EN && k == ev_idx + 3) begin
            en_i = 1'b1;
            #8 chk("en_on_busy", 32'(busy_o), 32'd1);
            #32;
         end else if (ev_kind == EV_RST && k == ev_idx) begin
            preset = 1'b1;
            #3;
            chk("async_rst_busy", 32'(busy_o), 32'd0);
            chk("async_rst_level", 32'(level_o), 32'd0);
            #4 preset = 1'b0;
            #33;
         end else begin
            #40;
         end
         sck_i = 1'b1;
         if (k == watch_idx) begin
            #32 chk("latency_cyc3", 32'(m_valid_o), 32'd0);
            #6  chk("latency_cyc4", 32'(m_valid_o), 32'd1);
            #2;
         end else begin
            #40;
         end
      end
      sck_i = 1'b0;
   endtask

   initial begin
      preset = 1'b1;
      en_i   = 1'b0;
      clr_i  = 1'b0;
      sck_i  = 1'b0;
      ws_i   = 1'b0;
      sd_i   = 1'b0;
`ifdef IIS_SLAVE_RX_LJ_EN
      lj_i   = 1'b0;
`endif
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_valid", 32'(m_valid_o), 32'd0);
      chk("rst_data", 32'(m_data_o), 32'd0);
      chk("rst_ch", 32'(m_ch_o), 32'd0);
      chk("rst_ovf", 32'(ovf_o), 32'd0);
      chk("rst_ferr", 32'(frame_err_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);

      // basic stereo frame, with latency on the first terminating edge
      start_scn();
      chk("busy_enabled", 32'(busy_o), 32'd1);
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 16, {16'hA5C3, 48'h0});
      add_slot(1'b1, 16, {16'h0F0F, 48'h0});
      add_slot(1'b0, 4, 64'h0);
      add_expect(1, 2);
      run_stream(1'b0, EV_NONE, -1, 31);
      finish_scn("basic");

      // long slots keep only the leading bits
      start_scn();
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 32, {32'h1234_5678, 32'h0});
      add_slot(1'b1, 32, {$urandom, $urandom});
      add_slot(1'b0, 4, 64'h0);
      add_expect(1, 2);
      run_stream(1'b0, EV_NONE, -1, -1);
      finish_scn("long_slot");

      // overflow with no drain, then clear and drain
      start_scn();
      rdy_fix = 1'b0;
      add_slot(1'b1, 16, 64'h0);
      for (int i = 0; i < 5; i++) add_slot(i % 2 == 1, 16, {$urandom, $urandom});
      add_slot(1'b1, 4, 64'h0);
      add_expect(1, 5);
      while (exp_q.size() > DEPTH) begin
         void'(exp_q.pop_back());
         exp_ovf = 1'b1;
      end
      run_stream(1'b0, EV_NONE, -1, -1);
      repeat (10) @(negedge pclk);
      chk("ovf_level", 32'(level_o), 32'(DEPTH));
      chk("ovf_flag", 32'(ovf_o), 32'(exp_ovf));
      chk("ovf_valid", 32'(m_valid_o), 32'd1);
      clr_i = 1'b1;
      @(negedge pclk);
      clr_i = 1'b0;
      exp_ovf = 1'b0;
      chk("ovf_cleared", 32'(ovf_o), 32'd0);
      rdy_fix = 1'b1;
      finish_scn("overflow");
      chk("ovf_level_empty", 32'(level_o), 32'd0);

      // short slot: dropped, flagged, following words intact
      start_scn();
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 10, {$urandom, $urandom});
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 16, {$urandom, $urandom});
      add_slot(1'b0, 4, 64'h0);
      add_expect(1, 4);
      run_stream(1'b0, EV_NONE, -1, -1);
      finish_scn("short_slot");
      clr_i = 1'b1;
      @(negedge pclk);
      clr_i = 1'b0;
      chk("ferr_cleared", 32'(frame_err_o), 32'd0);

      // enable dropped inside the third slot, restored three bits later
      start_scn();
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 16, {$urandom, $urandom});
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 16, {$urandom, $urandom});
      add_slot(1'b0, 4, 64'h0);
      add_expect(1, 1);
      add_expect(3, 4);
      run_stream(1'b0, EV_EN, 36, -1);
      finish_scn("en_drop");

      // reset in the middle of the first data slot
      start_scn();
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 16, {$urandom, $urandom});
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 4, 64'h0);
      add_expect(2, 3);
      run_stream(1'b0, EV_RST, 22, -1);
      finish_scn("mid_reset");

      // randomized slot lengths and data with a random ready pattern
      for (int r = 0; r < 2; r++) begin
         start_scn();
         rdy_rnd = 1'b1;
         add_slot(1'b1, 16, 64'h0);
         for (int i = 0; i < 6; i++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15))
                                               : int'($urandom_range(16, 30));
            add_slot(i % 2 == 1, len, {$urandom, $urandom});
         end
         add_slot(1'b0, 4, 64'h0);
         add_expect(1, 6);
         run_stream(1'b0, EV_NONE, -1, -1);
         finish_scn("random");
         rdy_rnd = 1'b0;
      end

`ifdef IIS_SLAVE_RX_LJ_EN
      // left-justified: alignment eats the first slot's MSB, later slots clean
      start_scn();
      lj_i = 1'b1;
      add_slot(1'b1, 16, 64'h0);
      add_slot(1'b0, 16, {$urandom, $urandom});
      add_slot(1'b1, 16, {$urandom, $urandom});
      add_slot(1'b0, 16, {16'h8001, 48'h0});
      add_slot(1'b1, 4, 64'h0);
      add_expect(2, 3);
      exp_ferr = 1'b1;
      run_stream(1'b1, EV_NONE, -1, -1);
      finish_scn("lj");
      lj_i = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
